// File: rtl/cpu_core_pkg.sv
// Shared core definitions: RV32I load/store func3 codes, MEM-stage FSM states and byte-lane helpers.
// The helper is_misaligned is only referenced when MAU_MISALIGN_TRAP_EN is defined.
package cpu_core_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int BE_WIDTH = 4;

  typedef enum logic [1:0] {
    MAU_IDLE,
    MAU_REQ,
    MAU_RDATA,
    MAU_DONE
  } mau_state_e;

  // func3[1:0] carries the access size for both loads and stores.
  function automatic logic [BE_WIDTH-1:0] store_be(input logic [2:0] func3, input logic [1:0] a);
    case (func3[1:0])
      2'b00:   store_be = 4'b0001 << a;
      2'b01:   store_be = a[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] func3, input logic [31:0] d);
    case (func3[1:0])
      2'b00:   store_wdata = {4{d[7:0]}};
      2'b01:   store_wdata = {2{d[15:0]}};
      default: store_wdata = d;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] func3, input logic [1:0] a);
    case (func3[1:0])
      2'b01:   is_misaligned = a[0];
      2'b10:   is_misaligned = (a != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mau_load_align.sv
// Load data alignment: picks the addressed byte/half of the read word and sign- or zero-extends it.
module mau_load_align
  import cpu_core_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  func3,
  input  logic [1:0]  a,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (a)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = a[1] ? rdata[31:16] : rdata[15:0];
    case (func3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'h000000, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'h0000, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: issues req/gnt/rvalid data-memory accesses, stalls while busy, registers MEM/WB.
// Optional MAU_MISALIGN_TRAP_EN: misaligned H/W accesses issue no request and pulse o_misaligned instead.
module mem_access_unit
  import cpu_core_pkg::*;
#(
  parameter int NB_PC      = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic                  i_regWrite,
  input  logic                  i_memRead,
  input  logic                  i_memWrite,
  input  logic                  i_memToReg,
  input  logic [2:0]            i_func3,
  input  logic [DATA_WIDTH-1:0] i_alu,
  input  logic [DATA_WIDTH-1:0] i_data2,
  input  logic [4:0]            i_rd_addr,
  input  logic [NB_PC-1:0]      i_pc_next,
  input  logic                  i_flush,
  output logic                  o_dmem_req,
  output logic                  o_dmem_we,
  output logic [DATA_WIDTH-1:0] o_dmem_addr,
  output logic [DATA_WIDTH-1:0] o_dmem_wdata,
  output logic [BE_WIDTH-1:0]   o_dmem_be,
  input  logic                  i_dmem_gnt,
  input  logic                  i_dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_dmem_rdata,
  output logic                  o_stall,
  output logic                  o_wb_valid,
  output logic                  o_wb_regWrite,
  output logic                  o_wb_memToReg,
  output logic [4:0]            o_wb_rd_addr,
  output logic [DATA_WIDTH-1:0] o_wb_alu,
  output logic [DATA_WIDTH-1:0] o_wb_load_data,
  output logic [NB_PC-1:0]      o_wb_pc_next,
  output logic                  o_misaligned
);

  mau_state_e state_q, state_d;

  logic                  op_we_q, op_we_d;
  logic [2:0]            op_func3_q, op_func3_d;
  logic [DATA_WIDTH-1:0] op_alu_q, op_alu_d;
  logic [DATA_WIDTH-1:0] op_data2_q, op_data2_d;
  logic                  op_reg_write_q, op_reg_write_d;
  logic                  op_mem_to_reg_q, op_mem_to_reg_d;
  logic [4:0]            op_rd_q, op_rd_d;
  logic [NB_PC-1:0]      op_pc_q, op_pc_d;

  logic                  wb_valid_q, wb_valid_d;
  logic                  wb_reg_write_q, wb_reg_write_d;
  logic                  wb_mem_to_reg_q, wb_mem_to_reg_d;
  logic [4:0]            wb_rd_addr_q, wb_rd_addr_d;
  logic [DATA_WIDTH-1:0] wb_alu_q, wb_alu_d;
  logic [DATA_WIDTH-1:0] wb_load_data_q, wb_load_data_d;
  logic [NB_PC-1:0]      wb_pc_next_q, wb_pc_next_d;
  logic                  misaligned_q, misaligned_d;

  logic                  idle, mem_op, trap, live_mem, req, retire;
  logic                  cur_we, cur_reg_write, cur_mem_to_reg;
  logic [2:0]            cur_func3;
  logic [DATA_WIDTH-1:0] cur_alu, cur_data2, load_ext;
  logic [4:0]            cur_rd;
  logic [NB_PC-1:0]      cur_pc;

  mau_load_align u_load_align (
    .rdata (i_dmem_rdata),
    .func3 (op_func3_q),
    .a     (op_alu_q[1:0]),
    .data  (load_ext)
  );

  // In IDLE the access is launched straight from EX/MEM; afterwards it runs from the latched copy.
  always_comb begin
    idle   = (state_q == MAU_IDLE);
    mem_op = i_rst_n & i_valid & (i_memRead | i_memWrite) & ~i_flush;
`ifdef MAU_MISALIGN_TRAP_EN
    trap   = mem_op & is_misaligned(i_func3, i_alu[1:0]);
`else
    trap   = 1'b0;
`endif
    live_mem       = mem_op & ~trap;
    req            = idle ? live_mem : (state_q == MAU_REQ);
    cur_we         = idle ? i_memWrite : op_we_q;
    cur_func3      = idle ? i_func3    : op_func3_q;
    cur_alu        = idle ? i_alu      : op_alu_q;
    cur_data2      = idle ? i_data2    : op_data2_q;
    cur_reg_write  = idle ? i_regWrite : op_reg_write_q;
    cur_mem_to_reg = idle ? i_memToReg : op_mem_to_reg_q;
    cur_rd         = idle ? i_rd_addr  : op_rd_q;
    cur_pc         = idle ? i_pc_next  : op_pc_q;
  end

  always_comb begin
    state_d         = state_q;
    op_we_d         = op_we_q;
    op_func3_d      = op_func3_q;
    op_alu_d        = op_alu_q;
    op_data2_d      = op_data2_q;
    op_reg_write_d  = op_reg_write_q;
    op_mem_to_reg_d = op_mem_to_reg_q;
    op_rd_d         = op_rd_q;
    op_pc_d         = op_pc_q;
    wb_valid_d      = 1'b0;
    wb_reg_write_d  = 1'b0;
    wb_mem_to_reg_d = 1'b0;
    wb_rd_addr_d    = '0;
    wb_alu_d        = '0;
    wb_load_data_d  = '0;
    wb_pc_next_d    = '0;
    misaligned_d    = 1'b0;
    retire          = 1'b0;
    case (state_q)
      MAU_IDLE: begin
        if (live_mem) begin
          op_we_d         = i_memWrite;
          op_func3_d      = i_func3;
          op_alu_d        = i_alu;
          op_data2_d      = i_data2;
          op_reg_write_d  = i_regWrite;
          op_mem_to_reg_d = i_memToReg;
          op_rd_d         = i_rd_addr;
          op_pc_d         = i_pc_next;
          if (i_dmem_gnt) state_d = i_memWrite ? MAU_DONE : MAU_RDATA;
          else            state_d = MAU_REQ;
          retire = i_dmem_gnt & i_memWrite;
        end else if (i_valid & ~i_flush) begin
          retire       = 1'b1;
          misaligned_d = trap;
        end
      end
      MAU_REQ: begin
        if (i_dmem_gnt) begin
          state_d = op_we_q ? MAU_DONE : MAU_RDATA;
          retire  = op_we_q;
        end
      end
      MAU_RDATA: begin
        if (i_dmem_rvalid) begin
          state_d        = MAU_DONE;
          retire         = 1'b1;
          wb_load_data_d = load_ext;
        end
      end
      default: state_d = MAU_IDLE;
    endcase
    if (retire) begin
      wb_valid_d      = 1'b1;
      wb_reg_write_d  = cur_reg_write & ~trap;
      wb_mem_to_reg_d = cur_mem_to_reg;
      wb_rd_addr_d    = cur_rd;
      wb_alu_d        = cur_alu;
      wb_pc_next_d    = cur_pc;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q         <= MAU_IDLE;
      op_we_q         <= 1'b0;
      op_func3_q      <= '0;
      op_alu_q        <= '0;
      op_data2_q      <= '0;
      op_reg_write_q  <= 1'b0;
      op_mem_to_reg_q <= 1'b0;
      op_rd_q         <= '0;
      op_pc_q         <= '0;
      wb_valid_q      <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      wb_rd_addr_q    <= '0;
      wb_alu_q        <= '0;
      wb_load_data_q  <= '0;
      wb_pc_next_q    <= '0;
      misaligned_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      op_we_q         <= op_we_d;
      op_func3_q      <= op_func3_d;
      op_alu_q        <= op_alu_d;
      op_data2_q      <= op_data2_d;
      op_reg_write_q  <= op_reg_write_d;
      op_mem_to_reg_q <= op_mem_to_reg_d;
      op_rd_q         <= op_rd_d;
      op_pc_q         <= op_pc_d;
      wb_valid_q      <= wb_valid_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_mem_to_reg_q <= wb_mem_to_reg_d;
      wb_rd_addr_q    <= wb_rd_addr_d;
      wb_alu_q        <= wb_alu_d;
      wb_load_data_q  <= wb_load_data_d;
      wb_pc_next_q    <= wb_pc_next_d;
      misaligned_q    <= misaligned_d;
    end
  end

  assign o_dmem_req     = req;
  assign o_dmem_we      = req & cur_we;
  assign o_dmem_addr    = req ? {cur_alu[DATA_WIDTH-1:2], 2'b00} : '0;
  assign o_dmem_wdata   = (req & cur_we) ? store_wdata(cur_func3, cur_data2) : '0;
  assign o_dmem_be      = req ? store_be(cur_func3, cur_alu[1:0]) : '0;
  // DONE is deliberately absent: the pipeline is released during the write-back cycle.
  assign o_stall        = (state_q == MAU_REQ) | (state_q == MAU_RDATA) | (idle & live_mem);
  assign o_wb_valid     = wb_valid_q;
  assign o_wb_regWrite  = wb_reg_write_q;
  assign o_wb_memToReg  = wb_mem_to_reg_q;
  assign o_wb_rd_addr   = wb_rd_addr_q;
  assign o_wb_alu       = wb_alu_q;
  assign o_wb_load_data = wb_load_data_q;
  assign o_wb_pc_next   = wb_pc_next_q;
  assign o_misaligned   = misaligned_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: driver pushes expected requests/write-backs, monitor pops and compares.
module tb_mem_access_unit;
  import cpu_core_pkg::*;

`ifdef MAU_MISALIGN_TRAP_EN
  localparam bit trapEn = 1'b1;
`else
  localparam bit trapEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid, i_regWrite, i_memRead, i_memWrite, i_memToReg, i_flush;
  logic [2:0]  i_func3;
  logic [31:0] i_alu, i_data2, i_pc_next, i_dmem_rdata;
  logic [4:0]  i_rd_addr;
  logic        i_dmem_gnt, i_dmem_rvalid;
  logic        o_dmem_req, o_dmem_we, o_stall, o_wb_valid, o_wb_regWrite, o_wb_memToReg, o_misaligned;
  logic [31:0] o_dmem_addr, o_dmem_wdata, o_wb_alu, o_wb_load_data, o_wb_pc_next;
  logic [3:0]  o_dmem_be;
  logic [4:0]  o_wb_rd_addr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } reqExp_t;

  typedef struct {
    logic        regWrite;
    logic        memToReg;
    logic        misaligned;
    logic        isLoad;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] loadData;
    logic [31:0] pcNext;
  } wbExp_t;

  reqExp_t reqQ[$];
  wbExp_t  wbQ[$];

  mem_access_unit #(.NB_PC(32), .DATA_WIDTH(32)) dut (
    .clk            (clk),
    .i_rst_n        (i_rst_n),
    .i_valid        (i_valid),
    .i_regWrite     (i_regWrite),
    .i_memRead      (i_memRead),
    .i_memWrite     (i_memWrite),
    .i_memToReg     (i_memToReg),
    .i_func3        (i_func3),
    .i_alu          (i_alu),
    .i_data2        (i_data2),
    .i_rd_addr      (i_rd_addr),
    .i_pc_next      (i_pc_next),
    .i_flush        (i_flush),
    .o_dmem_req     (o_dmem_req),
    .o_dmem_we      (o_dmem_we),
    .o_dmem_addr    (o_dmem_addr),
    .o_dmem_wdata   (o_dmem_wdata),
    .o_dmem_be      (o_dmem_be),
    .i_dmem_gnt     (i_dmem_gnt),
    .i_dmem_rvalid  (i_dmem_rvalid),
    .i_dmem_rdata   (i_dmem_rdata),
    .o_stall        (o_stall),
    .o_wb_valid     (o_wb_valid),
    .o_wb_regWrite  (o_wb_regWrite),
    .o_wb_memToReg  (o_wb_memToReg),
    .o_wb_rd_addr   (o_wb_rd_addr),
    .o_wb_alu       (o_wb_alu),
    .o_wb_load_data (o_wb_load_data),
    .o_wb_pc_next   (o_wb_pc_next),
    .o_misaligned   (o_misaligned)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference model: RV32I load extraction and store lane rules written as plain arithmetic.
  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] word);
    int unsigned b, h;
    b = (word >> (8 * a)) & 32'hFF;
    h = (word >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? b - 256 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? h - 65536 : h;
      3'b101:  return h;
      default: return word;
    endcase
  endfunction

  function automatic logic [3:0] modelBe(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000:  return 4'(1 << a);
      3'b001:  return (a >= 2) ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return (d & 32'hFF) * 32'h01010101;
      3'b001:  return (d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req"},        o_dmem_req,     0);
    checkOutput({tag, "_addr"},       o_dmem_addr,    0);
    checkOutput({tag, "_be"},         o_dmem_be,      0);
    checkOutput({tag, "_stall"},      o_stall,        0);
    checkOutput({tag, "_wb_valid"},   o_wb_valid,     0);
    checkOutput({tag, "_wb_regw"},    o_wb_regWrite,  0);
    checkOutput({tag, "_wb_rd"},      o_wb_rd_addr,   0);
    checkOutput({tag, "_wb_alu"},     o_wb_alu,       0);
    checkOutput({tag, "_wb_load"},    o_wb_load_data, 0);
    checkOutput({tag, "_wb_pc"},      o_wb_pc_next,   0);
    checkOutput({tag, "_misaligned"}, o_misaligned,   0);
  endtask

  // kind: 0 = non-memory op, 1 = load, 2 = store. Holds the instruction while o_stall is high.
  task automatic applyStimulus(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] data2, input logic [31:0] rdata,
                               input int gntDly, input int rvDly, input bit flushIdle, input bit flushLater,
                               input logic regWrite, input logic memToReg, input logic [4:0] rd,
                               input logic [31:0] pc);
    bit      isMem, isLoad, trap, done;
    int      expStall, stallCount, cyc;
    reqExp_t re;
    wbExp_t  we;
    isMem  = (kind != 0);
    isLoad = (kind == 1);
    trap   = trapEn && isMem && ((f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00));
    expStall = 0;
    if (!flushIdle) begin
      if (isMem && !trap) begin
        re.addr  = addr & ~32'h3;
        re.we    = !isLoad;
        re.wdata = isLoad ? 32'h0 : modelWdata(f3, data2);
        re.be    = modelBe(f3, addr[1:0]);
        reqQ.push_back(re);
        expStall = isLoad ? gntDly + rvDly + 1 : gntDly + 1;
      end
      we.regWrite   = trap ? 1'b0 : regWrite;
      we.memToReg   = memToReg;
      we.misaligned = trap;
      we.isLoad     = isLoad && !trap;
      we.rd         = rd;
      we.alu        = addr;
      we.loadData   = modelLoad(f3, addr[1:0], rdata);
      we.pcNext     = pc;
      wbQ.push_back(we);
    end
    i_valid    = 1'b1;
    i_memRead  = isLoad;
    i_memWrite = (kind == 2);
    i_regWrite = regWrite;
    i_memToReg = memToReg;
    i_func3    = f3;
    i_alu      = addr;
    i_data2    = data2;
    i_rd_addr  = rd;
    i_pc_next  = pc;
    stallCount = 0;
    cyc        = 0;
    done       = 1'b0;
    while (!done) begin
      i_dmem_gnt    = isMem && !flushIdle && !trap && (cyc == gntDly);
      i_dmem_rvalid = isLoad && !flushIdle && !trap && (cyc == gntDly + rvDly);
      i_dmem_rdata  = i_dmem_rvalid ? rdata : $urandom;
      i_flush       = (cyc == 0) ? flushIdle : flushLater;
      @(negedge clk);
      if (o_stall) stallCount++;
      else done = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
      if (!done && cyc > 40) begin
        checkOutput("stall_timeout", cyc, 40);
        done = 1'b1;
      end
    end
    checkOutput("stall_cycles", stallCount, expStall);
    i_valid       = 1'b0;
    i_memRead     = 1'b0;
    i_memWrite    = 1'b0;
    i_flush       = 1'b0;
    i_dmem_gnt    = 1'b0;
    i_dmem_rvalid = 1'b0;
  endtask

  // Monitor: request fields are checked every cycle req is up (so they must stay stable) and popped on gnt.
  always @(negedge clk) begin : monitor
    reqExp_t re;
    wbExp_t  we;
    if (i_rst_n) begin
      if (o_dmem_req) begin
        if (reqQ.size() == 0) begin
          checkOutput("unexpected_req", {31'h0, o_dmem_req}, 32'h0);
        end else begin
          re = reqQ[0];
          checkOutput("req_addr", o_dmem_addr, re.addr);
          checkOutput("req_we",   o_dmem_we,   re.we);
          if (re.we) begin
            checkOutput("req_wdata", o_dmem_wdata, re.wdata);
            checkOutput("req_be",    o_dmem_be,    re.be);
          end
          if (i_dmem_gnt) void'(reqQ.pop_front());
        end
      end
      if (o_wb_valid) begin
        if (wbQ.size() == 0) begin
          checkOutput("unexpected_wb", {31'h0, o_wb_valid}, 32'h0);
        end else begin
          we = wbQ.pop_front();
          checkOutput("wb_regWrite",   o_wb_regWrite, we.regWrite);
          checkOutput("wb_memToReg",   o_wb_memToReg, we.memToReg);
          checkOutput("wb_rd_addr",    o_wb_rd_addr,  we.rd);
          checkOutput("wb_alu",        o_wb_alu,      we.alu);
          checkOutput("wb_pc_next",    o_wb_pc_next,  we.pcNext);
          checkOutput("wb_misaligned", o_misaligned,  we.misaligned);
          if (we.isLoad) checkOutput("wb_load_data", o_wb_load_data, we.loadData);
        end
      end
    end
  end

  logic [2:0] loadCodes[5];
  initial begin
    int kind, gntDly, rvDly;
    bit flushIdle, flushLater;
    logic [2:0] f3;
    loadCodes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    i_rst_n = 1'b0;
    i_valid = 1'b0; i_regWrite = 1'b0; i_memRead = 1'b0; i_memWrite = 1'b0; i_memToReg = 1'b0;
    i_flush = 1'b0; i_func3 = 3'b0; i_alu = 32'h0; i_data2 = 32'h0; i_rd_addr = 5'h0; i_pc_next = 32'h0;
    i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    i_rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(2, F3_B,  32'h00001003, 32'h000000AB, 32'h0,        0, 1, 0, 0, 1'b0, 1'b0, 5'd0, 32'h104);
    applyStimulus(1, F3_B,  32'h00002001, 32'h0,        32'h00008000, 0, 1, 0, 0, 1'b1, 1'b1, 5'd5, 32'h108);
    applyStimulus(1, F3_BU, 32'h00002001, 32'h0,        32'h00008000, 0, 1, 0, 0, 1'b1, 1'b1, 5'd6, 32'h10C);
    applyStimulus(1, F3_HU, 32'h00002002, 32'h0,        32'hBEEF0000, 0, 1, 0, 0, 1'b1, 1'b1, 5'd7, 32'h110);
    applyStimulus(1, F3_W,  32'h00002004, 32'h0,        32'hCAFEF00D, 3, 2, 0, 0, 1'b1, 1'b1, 5'd8, 32'h114);
    applyStimulus(1, F3_W,  32'h00002008, 32'h0,        32'h11111111, 0, 1, 1, 0, 1'b1, 1'b1, 5'd9, 32'h118);
    applyStimulus(1, F3_H,  32'h0000200E, 32'h0,        32'h80017FFF, 2, 1, 0, 1, 1'b1, 1'b1, 5'd10, 32'h11C);
    applyStimulus(2, F3_W,  32'h00002010, 32'hDEADBEEF, 32'h0,        1, 1, 0, 1, 1'b0, 1'b0, 5'd0, 32'h120);
    applyStimulus(0, F3_W,  32'h12345678, 32'h0,        32'h0,        0, 1, 0, 0, 1'b1, 1'b0, 5'd11, 32'h124);
    applyStimulus(1, F3_W,  32'h00003002, 32'h0,        32'h0BADC0DE, 1, 1, 0, 0, 1'b1, 1'b1, 5'd12, 32'h128);
    applyStimulus(2, F3_H,  32'h00003006, 32'h1234ABCD, 32'h0,        0, 1, 0, 0, 1'b0, 1'b0, 5'd0, 32'h12C);

    // Reset while waiting for read data: outputs clear at once and a late rvalid is ignored.
    re_push: begin
      reqExp_t re;
      re.addr = 32'h00004000; re.we = 1'b0; re.wdata = 32'h0; re.be = 4'hF;
      reqQ.push_back(re);
    end
    i_valid = 1'b1; i_memRead = 1'b1; i_regWrite = 1'b1; i_memToReg = 1'b1; i_func3 = F3_W;
    i_alu = 32'h00004000; i_rd_addr = 5'd13; i_pc_next = 32'h130; i_dmem_gnt = 1'b1;
    @(posedge clk);
    #1;
    i_dmem_gnt = 1'b0;
    @(negedge clk);
    checkOutput("rdata_stall", o_stall, 1);
    #1;
    i_rst_n = 1'b0;
    #1;
    checkResetOutputs("mid_reset");
    @(posedge clk);
    #1;
    i_valid = 1'b0; i_memRead = 1'b0; i_regWrite = 1'b0; i_memToReg = 1'b0;
    i_rst_n = 1'b1;
    i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h55AA55AA;
    @(posedge clk);
    #1;
    i_dmem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("late_rvalid_wb", o_wb_valid, 0);
    end
    @(posedge clk);
    #1;

    for (int n = 0; n < 40; n++) begin
      kind       = $urandom_range(0, 2);
      f3         = (kind == 2) ? 3'($urandom_range(0, 2)) : loadCodes[$urandom_range(0, 4)];
      gntDly     = $urandom_range(0, 3);
      rvDly      = $urandom_range(1, 3);
      flushIdle  = ($urandom_range(0, 7) == 0);
      flushLater = (kind != 0) && ($urandom_range(0, 3) == 0);
      applyStimulus(kind, f3, $urandom, $urandom, $urandom, gntDly, rvDly, flushIdle, flushLater,
                    (kind == 2) ? 1'b0 : 1'($urandom_range(0, 1)), (kind == 1),
                    5'($urandom_range(1, 31)), $urandom);
    end

    repeat (5) @(posedge clk);
    #1;
    checkOutput("req_queue_empty", reqQ.size(), 0);
    checkOutput("wb_queue_empty",  wbQ.size(),  0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
